// File: rtl/fpu_pkg.sv
// Shared FPU sequencing types: opcodes, flag bit positions, IEEE-754 single field widths.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam int unsigned FLAG_W = 5;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside a {invalid,overflow,underflow,inexact,zero} flag vector
    localparam int unsigned FLG_ZERO      = 0;
    localparam int unsigned FLG_INEXACT   = 1;
    localparam int unsigned FLG_UNDERFLOW = 2;
    localparam int unsigned FLG_OVERFLOW  = 3;
    localparam int unsigned FLG_INVALID   = 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp_fields_t;

    function automatic logic [FLAG_W-1:0] flag_only(input int unsigned idx);
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fpu_field_pack.sv
// Combinational IEEE-754 single field split for both operands and re-pack of the result.
module fpu_field_pack
    import fpu_pkg::*;
(
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b_word,
    input  logic              z_s,
    input  logic [EXP_W-1:0]  z_e,
    input  logic [MAN_W-1:0]  z_m,
    output fp_fields_t        x_f,
    output fp_fields_t        y_f,
    output logic [WORD_W-1:0] z_word
);

    always_comb begin
        x_f.s  = a_word[WORD_W-1];
        x_f.e  = a_word[WORD_W-2 -: EXP_W];
        x_f.m  = a_word[MAN_W-1:0];
        y_f.s  = b_word[WORD_W-1];
        y_f.e  = b_word[WORD_W-2 -: EXP_W];
        y_f.m  = b_word[MAN_W-1:0];
        z_word = {z_s, z_e, z_m};
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// One-in-flight command sequencer in front of a fixed-latency FPU.
// Optional sticky flag accumulator enabled by defining FPU_SEQ_STICKY_FLAGS_EN.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WORD_W-1:0] cmd_a,
    input  logic [WORD_W-1:0] cmd_b,
    input  logic [1:0]        cmd_rmode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              Sx,
    output logic              Sy,
    output logic [EXP_W-1:0]  Ex,
    output logic [EXP_W-1:0]  Ey,
    output logic [MAN_W-1:0]  Mx,
    output logic [MAN_W-1:0]  My,
    output logic              en_add_mul,
    output logic              sub,
    output logic [1:0]        roundMode,
    input  logic              Sz,
    input  logic [EXP_W-1:0]  Ez,
    input  logic [MAN_W-1:0]  Mz,
    input  logic              invalid_flag,
    input  logic              overflow_flag,
    input  logic              underflow_flag,
    input  logic              inexact_flag,
`ifdef FPU_SEQ_STICKY_FLAGS_EN
    input  logic              sticky_clr,
    output logic [FLAG_W-1:0] sticky_flags,
`endif
    input  logic              zero_flag
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    fpu_op_e           op_q, op_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [1:0]        rmode_q, rmode_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

    fp_fields_t        x_f, y_f;
    logic [WORD_W-1:0] z_word;
    logic [FLAG_W-1:0] fpu_flags;
    logic              fpu_active;

    fpu_field_pack u_pack (
        .a_word (a_q),
        .b_word (b_q),
        .z_s    (Sz),
        .z_e    (Ez),
        .z_m    (Mz),
        .x_f    (x_f),
        .y_f    (y_f),
        .z_word (z_word)
    );

    assign fpu_flags = {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rmode_d     = rmode_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = fpu_op_e'(cmd_op);
                    a_d         = cmd_a;
                    b_d         = cmd_b;
                    rmode_d     = cmd_rmode;
                    cmd_ready_d = 1'b0;
                    // Reserved opcode never reaches the FPU; answer with a quiet NaN.
                    if (fpu_op_e'(cmd_op) == OP_RSVD) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = QNAN;
                        rsp_flags_d = flag_only(FLG_INVALID);
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = z_word;
                    rsp_flags_d = fpu_flags;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            rmode_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rmode_q     <= rmode_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

    // FPU sees the held command only while ISSUE/WAIT; otherwise a quiet idle vector.
    assign fpu_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    always_comb begin
        Sx         = fpu_active ? x_f.s : 1'b0;
        Sy         = fpu_active ? y_f.s : 1'b0;
        Ex         = fpu_active ? x_f.e : '0;
        Ey         = fpu_active ? y_f.e : '0;
        Mx         = fpu_active ? x_f.m : '0;
        My         = fpu_active ? y_f.m : '0;
        roundMode  = fpu_active ? rmode_q : '0;
        en_add_mul = fpu_active ? (op_q != OP_MUL) : 1'b1;
        sub        = fpu_active && (op_q == OP_SUB);
    end

`ifdef FPU_SEQ_STICKY_FLAGS_EN
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = '0;
        end else if (rsp_valid_q && rsp_ready) begin
            sticky_d = sticky_q | rsp_flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 3, giving the FPU cycles from operand drive to valid result (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-low reset.
REQ-004 SHALL have cmd_valid/cmd_ready, in/out, 1 each, for the command handshake.
REQ-005 SHALL have cmd_op, in, 2, encoded as 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-006 SHALL have cmd_a/cmd_b, in, 32 each, as packed IEEE-754 single operands; cmd_rmode, in, 2, as the rounding mode.
REQ-007 SHALL have rsp_valid/rsp_ready, out/in, 1 each, for the response handshake.
REQ-008 SHALL have rsp_data, out, 32, the packed result, and rsp_flags, out, 5, ordered {invalid,overflow,underflow,inexact,zero}.
REQ-009 SHALL have FPU-side outputs Sx,Sy (1), Ex,Ey (8), Mx,My (23), en_add_mul (1, add=1), sub (1) and roundMode (2).
REQ-010 SHALL have FPU-side inputs Sz (1), Ez (8), Mz (23), and invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag (1 each).

Function
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-012 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-013 On accept, SHALL register the command and go to ISSUE for exactly one cycle.
REQ-014 SHALL drive the FPU operand and control outputs from the registered command, held stable through ISSUE and all of WAIT.
REQ-015 SHALL unpack fields as S = bit31, E = bits30:23, M = bits22:0.
REQ-016 SHALL decode ADD as en_add_mul=1, sub=0; SUB as en_add_mul=1, sub=1; MUL as en_add_mul=0, sub=0.
REQ-017 SHALL load a 4-bit counter with LATENCY-1 on entering WAIT, decrement it each cycle, and leave WAIT when it reads 0.
REQ-018 On the final WAIT cycle, SHALL capture {Sz,Ez,Mz} into rsp_data and the five FPU flags into rsp_flags.
REQ-019 SHALL make rsp_valid rise exactly LATENCY+2 cycles after the accept edge.
REQ-020 In DONE, SHALL hold rsp_valid high and rsp_data/rsp_flags stable until rsp_ready; on rsp_valid && rsp_ready, SHALL return to IDLE.
REQ-021 SHALL allow the next accept no earlier than the cycle after the handshake, giving one command in flight at most.
REQ-022 For reserved op 11, SHALL skip ISSUE/WAIT and go straight to DONE the cycle after accept, with rsp_data=0x7FC00000 and rsp_flags=5'b10000.
REQ-023 Outside ISSUE/WAIT, SHALL drive all FPU operand outputs to 0 and en_add_mul to 1.
REQ-024 SHALL ignore cmd_valid in every state other than IDLE; no command is queued.

Reset
REQ-025 When rst=0 at a clk edge, SHALL go to IDLE and clear the counter and the command register.
REQ-026 During reset, SHALL drive rsp_valid=0, rsp_data=0, rsp_flags=0 and cmd_ready=0; cmd_ready SHALL be 1 the first cycle after release.
REQ-027 Reset mid-operation (ISSUE, WAIT or DONE) SHALL drop the pending response, and no rsp_valid SHALL follow for that command.

Configuration
REQ-028 With macro FPU_SEQ_STICKY_FLAGS_EN defined, SHALL add output sticky_flags (5, same order as rsp_flags), which ORs in rsp_flags at each response handshake.
REQ-029 Under FPU_SEQ_STICKY_FLAGS_EN, sticky_flags SHALL clear only on reset or on an input sticky_clr (1), with clear taking priority over set in the same cycle.
REQ-030 Without the macro, the sticky_flags and sticky_clr ports and their logic SHALL be absent.

Structure
REQ-031 SHALL take from shared package fpu_pkg: the opcode typedef (OP_ADD/OP_SUB/OP_MUL/OP_RSVD), the flag index constants, the field widths (EXP_W=8, MAN_W=23) and QNAN=32'h7FC00000.
REQ-032 SHALL place pack/unpack of the IEEE fields in one combinational sub-module, fpu_field_pack.

Verification
REQ-033 With LATENCY=3, ADD of a=0x3F800000 and b=0x40000000, model returning 0x40400000 -> rsp_valid at accept+5, rsp_data=0x40400000, rsp_flags=0.
REQ-034 SUB with a=b=0x40A00000 -> sub=1 and en_add_mul=1 held for 4 cycles; model zero result gives rsp_data=0x00000000 and rsp_flags=5'b00001.
REQ-035 MUL of 0x7F000000 by 0x40000000, model overflow -> en_add_mul=0 and rsp_flags=5'b01000; rsp_ready held low for 6 cycles -> rsp_data stable and cmd_ready=0 throughout.
REQ-036 Reserved op=11 -> rsp_valid at accept+1, rsp_data=0x7FC00000, rsp_flags=5'b10000, and no FPU operand toggles.
REQ-037 rst=0 during WAIT cycle 2 -> no rsp_valid for that command; a new ADD accepted after release completes normally.
REQ-038 With FPU_SEQ_STICKY_FLAGS_EN, an inexact response then an overflow response -> sticky_flags=5'b01010; sticky_clr pulsed together with a handshake -> sticky_flags=0.
